// File: rtl/gtp_link_ctrl.sv
// Bring-up and supervision FSM for a 4-lane GTP receiver: reset, PLL/DCM lock, RESETDONE, comma alignment, link monitor.
// Outputs are registered from the next state, so they change on the same edge as state; every lane input is sampled each cycle.
module gtp_link_ctrl #(
  parameter int RST_CYCLES = 64,
  parameter int LOCK_TMO   = 65536,
  parameter int ALIGN_CNT  = 16,
  parameter int ALIGN_TMO  = 4096,
  parameter int IDLE_TMO   = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        restart,
  input  logic        pll_lock,
  input  logic        dcm_locked,
  input  logic [3:0]  resetdone,
  input  logic [3:0]  lossofsync,
  input  logic [63:0] data,
  input  logic [3:0]  charisk,
  output logic        gtp_reset,
  output logic        dcm_reset,
  output logic        link_up,
  output logic [3:0]  lane_ok,
  output logic [7:0]  retry_cnt,
  output logic [2:0]  state
);
  localparam logic [2:0] S_RESET   = 3'd0;
  localparam logic [2:0] S_WAITPLL = 3'd1;
  localparam logic [2:0] S_WAITDCM = 3'd2;
  localparam logic [2:0] S_WAITRDY = 3'd3;
  localparam logic [2:0] S_ALIGN   = 3'd4;
  localparam logic [2:0] S_UP      = 3'd5;

  localparam int              IW         = $clog2(IDLE_TMO + 1);
  localparam logic [16:0]     RST_LAST   = 17'(RST_CYCLES - 1);
  localparam logic [16:0]     LOCK_LAST  = 17'(LOCK_TMO - 1);
  localparam logic [16:0]     ALIGN_LAST = 17'(ALIGN_TMO - 1);
  localparam logic [4:0]      ALIGN_HIT  = 5'(ALIGN_CNT);
  localparam logic [IW-1:0]   IDLE_LAST  = IW'(IDLE_TMO - 1);

  logic [16:0]   timer;
  logic [4:0]    align_cnt [4];
  logic [IW-1:0] idle_cnt  [4];
  logic [3:0]    comma, align_hit, idle_hit;
  logic          fail;
  logic [2:0]    nxt_state;
  logic          nxt_gtp_reset, nxt_dcm_reset, nxt_link_up;
  logic [3:0]    nxt_lane_ok;

  // Only the low byte of each lane word identifies a comma.
  logic unused_hi_bytes;
  assign unused_hi_bytes = ^{data[63:56], data[47:40], data[31:24], data[15:8]};

  always_comb begin
    comma     = '0;
    align_hit = '0;
    idle_hit  = '0;
    for (int i = 0; i < 4; i++) begin
      comma[i]     = charisk[i] && (data[16*i +: 8] == 8'hBC);
      align_hit[i] = (align_cnt[i] == ALIGN_HIT);
      idle_hit[i]  = !comma[i] && (idle_cnt[i] == IDLE_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RESET;
      timer <= '0;
    end else begin
      state <= nxt_state;
      timer <= (restart || (nxt_state != state)) ? 17'd0 : timer + 17'd1;
    end
  end

  always_comb begin
    nxt_state = state;
    fail      = 1'b0;
    case (state)
      S_RESET:   if (timer == RST_LAST) nxt_state = S_WAITPLL;
      S_WAITPLL: if (pll_lock) nxt_state = S_WAITDCM;
                 else if (timer == LOCK_LAST) fail = 1'b1;
      S_WAITDCM: if (!pll_lock) fail = 1'b1;
                 else if (dcm_locked) nxt_state = S_WAITRDY;
                 else if (timer == LOCK_LAST) fail = 1'b1;
      S_WAITRDY: if (!pll_lock) fail = 1'b1;
                 else if (&resetdone) nxt_state = S_ALIGN;
                 else if (timer == LOCK_LAST) fail = 1'b1;
      S_ALIGN:   if (!pll_lock || !dcm_locked) fail = 1'b1;
                 else if (&lane_ok) nxt_state = S_UP;
                 else if (timer == ALIGN_LAST) fail = 1'b1;
      S_UP:      if (!pll_lock || !dcm_locked || (|lossofsync) || (|idle_hit)) fail = 1'b1;
      default:   nxt_state = S_RESET;
    endcase
    if (restart || fail) nxt_state = S_RESET;
  end

  always_comb begin
    nxt_gtp_reset = (nxt_state == S_RESET);
    nxt_dcm_reset = (nxt_state == S_RESET) || (nxt_state == S_WAITPLL);
    nxt_link_up   = (nxt_state == S_UP);
    nxt_lane_ok   = 4'h0;
    if ((nxt_state == S_ALIGN) && (state == S_ALIGN)) nxt_lane_ok = lane_ok | align_hit;
    else if (nxt_state == S_UP)                      nxt_lane_ok = lane_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gtp_reset <= 1'b1;
      dcm_reset <= 1'b1;
      link_up   <= 1'b0;
      lane_ok   <= 4'h0;
      retry_cnt <= 8'd0;
    end else begin
      gtp_reset <= nxt_gtp_reset;
      dcm_reset <= nxt_dcm_reset;
      link_up   <= nxt_link_up;
      lane_ok   <= nxt_lane_ok;
      // A restart request in the same cycle masks the failure.
      if (fail && !restart && (retry_cnt != 8'hFF)) retry_cnt <= retry_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        align_cnt[i] <= '0;
        idle_cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (state != S_ALIGN)  align_cnt[i] <= '0;
        else if (!lane_ok[i])  align_cnt[i] <= comma[i] ? align_cnt[i] + 5'd1 : 5'd0;
        if ((state != S_UP) || comma[i]) idle_cnt[i] <= '0;
        else                             idle_cnt[i] <= idle_cnt[i] + IW'(1);
      end
    end
  end
endmodule

// File: tb/tb_gtp_link_ctrl.sv
// Directed plus randomized bench for gtp_link_ctrl with a cycle-level reference model.
module tb_gtp_link_ctrl;
  localparam int RST_CYCLES = 4;
  localparam int LOCK_TMO   = 100;
  localparam int ALIGN_CNT  = 4;
  localparam int ALIGN_TMO  = 50;
  localparam int IDLE_TMO   = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        restart = 1'b0;
  logic        pll_lock = 1'b0;
  logic        dcm_locked = 1'b0;
  logic [3:0]  resetdone = 4'h0;
  logic [3:0]  lossofsync = 4'h0;
  logic [63:0] data = 64'h0;
  logic [3:0]  charisk = 4'h0;
  logic        gtp_reset, dcm_reset, link_up;
  logic [3:0]  lane_ok;
  logic [7:0]  retry_cnt;
  logic [2:0]  state;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int cyc    = 0;

  // Reference model: phase number, cycles spent in phase, per-lane comma streaks / idle runs.
  int         m_phase, m_dwell, m_retry;
  int         m_streak [4];
  int         m_idle   [4];
  logic [3:0] m_ok;

  gtp_link_ctrl #(
    .RST_CYCLES(RST_CYCLES), .LOCK_TMO(LOCK_TMO), .ALIGN_CNT(ALIGN_CNT),
    .ALIGN_TMO(ALIGN_TMO), .IDLE_TMO(IDLE_TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .restart(restart), .pll_lock(pll_lock),
    .dcm_locked(dcm_locked), .resetdone(resetdone), .lossofsync(lossofsync),
    .data(data), .charisk(charisk), .gtp_reset(gtp_reset), .dcm_reset(dcm_reset),
    .link_up(link_up), .lane_ok(lane_ok), .retry_cnt(retry_cnt), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_dwell = 0; m_retry = 0; m_ok = 4'h0;
    for (int i = 0; i < 4; i++) begin
      m_streak[i] = 0;
      m_idle[i]   = 0;
    end
  endtask

  task automatic model_step();
    bit         bad = 1'b0;
    int         nph = m_phase;
    logic [3:0] cm;
    logic [3:0] was_ok = m_ok;
    for (int i = 0; i < 4; i++) cm[i] = charisk[i] && (data[16*i +: 8] == 8'hBC);
    case (m_phase)
      0: if (m_dwell + 1 >= RST_CYCLES) nph = 1;
      1: if (pll_lock) nph = 2; else if (m_dwell + 1 >= LOCK_TMO) bad = 1'b1;
      2: if (!pll_lock) bad = 1'b1; else if (dcm_locked) nph = 3;
         else if (m_dwell + 1 >= LOCK_TMO) bad = 1'b1;
      3: if (!pll_lock) bad = 1'b1; else if (resetdone == 4'hF) nph = 4;
         else if (m_dwell + 1 >= LOCK_TMO) bad = 1'b1;
      4: if (!pll_lock || !dcm_locked) bad = 1'b1; else if (m_ok == 4'hF) nph = 5;
         else if (m_dwell + 1 >= ALIGN_TMO) bad = 1'b1;
      5: begin
        if (!pll_lock || !dcm_locked || (lossofsync != 4'h0)) bad = 1'b1;
        for (int i = 0; i < 4; i++) if (!cm[i] && (m_idle[i] + 1 >= IDLE_TMO)) bad = 1'b1;
      end
      default: nph = 0;
    endcase
    if (restart) nph = 0;
    else if (bad) begin
      nph = 0;
      if (m_retry < 255) m_retry++;
    end
    for (int i = 0; i < 4; i++) begin
      if (m_phase == 4 && nph == 4) begin
        if (m_streak[i] >= ALIGN_CNT) m_ok[i] = 1'b1;
      end else if (nph != 5) m_ok[i] = 1'b0;
      if (nph != 4) m_streak[i] = 0;
      else if (m_phase == 4 && !was_ok[i]) m_streak[i] = cm[i] ? m_streak[i] + 1 : 0;
      m_idle[i] = (m_phase == 5 && nph == 5 && !cm[i]) ? m_idle[i] + 1 : 0;
    end
    m_dwell = (restart || nph != m_phase) ? 0 : m_dwell + 1;
    m_phase = nph;
  endtask

  task automatic tick();
    logic [17:0] exp_v;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    exp_v = {3'(m_phase), m_phase == 0, m_phase <= 1, m_phase == 5, m_ok, 8'(m_retry)};
    check("cycle", {14'd0, state, gtp_reset, dcm_reset, link_up, lane_ok, retry_cnt}, {14'd0, exp_v});
  endtask

  // Good lanes carry a comma; bad lanes carry a non-comma (either a data word or a wrong K code).
  task automatic drive_lanes(input logic [3:0] good);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] lo;
      lo = 8'($urandom);
      if (good[i]) begin
        data[16*i +: 16] = {8'($urandom), 8'hBC};
        charisk[i] = 1'b1;
      end else begin
        if (lo == 8'hBC) lo = 8'h3C;
        data[16*i +: 16] = {8'($urandom), lo};
        charisk[i] = 1'($urandom);
      end
    end
  endtask

  task automatic bring_up(input int target, input logic [3:0] mask, input string tag);
    pll_lock = 1'b1; dcm_locked = 1'b1; resetdone = 4'hF; lossofsync = 4'h0;
    restart = 1'b1;
    drive_lanes(mask);
    tick();
    restart = 1'b0;
    for (int k = 0; k < 40 && m_phase != target; k++) begin
      drive_lanes(mask);
      tick();
    end
    check(tag, state, target);
  endtask

  initial begin
    model_reset();
    #12;
    check("rst_state", state, 0);
    check("rst_gtp_reset", gtp_reset, 1);
    check("rst_dcm_reset", dcm_reset, 1);
    check("rst_link_up", link_up, 0);
    check("rst_lane_ok", lane_ok, 0);
    check("rst_retry", retry_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Clean bring-up with the scripted lock timeline.
    drive_lanes(4'hF);
    for (int k = 0; k < 3; k++) tick();
    check("gtp_reset_held", gtp_reset, 1);
    tick();
    check("gtp_reset_low", gtp_reset, 0);
    check("enter_waitpll", state, 1);
    while (cyc < 30 && m_phase != 4) begin
      pll_lock   = (cyc >= 10);
      dcm_locked = (cyc >= 20);
      resetdone  = (cyc >= 25) ? 4'hF : 4'h0;
      drive_lanes(4'hF);
      tick();
    end
    check("reach_align", state, 4);
    for (int k = 0; k < 4; k++) begin drive_lanes(4'hF); tick(); end
    check("lane_ok_early", lane_ok, 0);
    drive_lanes(4'hF); tick();
    check("lane_ok_all", lane_ok, 4'hF);
    check("link_up_early", link_up, 0);
    drive_lanes(4'hF); tick();
    check("link_up", link_up, 1);
    check("clean_retry", retry_cnt, 0);

    // Lane 1 stops sending commas.
    for (int k = 0; k < 3; k++) begin drive_lanes(4'hF); tick(); end
    for (int k = 0; k < 7; k++) begin drive_lanes(4'b1101); tick(); end
    check("idle_7_still_up", link_up, 1);
    drive_lanes(4'b1101); tick();
    check("idle_8_down", link_up, 0);
    check("idle_state", state, 0);
    check("idle_retry", retry_cnt, 1);

    // lossofsync[3] pulse, then the same pulse together with restart.
    bring_up(5, 4'hF, "los_up");
    lossofsync = 4'b1000; drive_lanes(4'hF); tick(); lossofsync = 4'h0;
    check("los_state", state, 0);
    check("los_retry", retry_cnt, 2);
    bring_up(5, 4'hF, "los_rs_up");
    lossofsync = 4'b1000; restart = 1'b1; drive_lanes(4'hF); tick();
    lossofsync = 4'h0; restart = 1'b0;
    check("los_rs_state", state, 0);
    check("los_rs_retry", retry_cnt, 2);

    // Lane 2 carries 0x1234 data and never aligns.
    bring_up(4, 4'b1011, "l2_align");
    for (int k = 1; k < ALIGN_TMO; k++) begin
      drive_lanes(4'hF); data[47:32] = 16'h1234; charisk[2] = 1'b0;
      tick();
      if (k == 5) check("l2_lane_ok", lane_ok, 4'b1011);
    end
    check("l2_before_tmo", state, 4);
    drive_lanes(4'hF); data[47:32] = 16'h1234; charisk[2] = 1'b0;
    tick();
    check("l2_tmo_state", state, 0);
    check("l2_retry", retry_cnt, 3);

    // PLL never locks: three timeout loops.
    pll_lock = 1'b0; restart = 1'b1; tick(); restart = 1'b0;
    for (int l = 0; l < 3; l++) begin
      for (int t = 0; t < RST_CYCLES + LOCK_TMO - 1; t++) tick();
      check("pll_before_tmo", state, 1);
      tick();
      check("pll_tmo_state", state, 0);
      check("pll_tmo_retry", retry_cnt, 4 + l);
    end

    // Randomized traffic with alternating quiet and noisy lane segments.
    for (int n = 0; n < 4000; n++) begin
      logic [3:0] mask;
      bit noisy;
      noisy = ((n / 250) % 2) == 1;
      for (int i = 0; i < 4; i++)
        mask[i] = noisy ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 15) != 0);
      pll_lock   = ($urandom_range(0, 299) != 0);
      dcm_locked = ($urandom_range(0, 299) != 0);
      resetdone  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      lossofsync = ($urandom_range(0, 399) == 0) ? 4'($urandom) : 4'h0;
      restart    = ($urandom_range(0, 799) == 0);
      drive_lanes(mask);
      tick();
    end
    restart = 1'b0; lossofsync = 4'h0;

    // Asynchronous reset while aligning, with lane_ok already set.
    bring_up(4, 4'hF, "mid_align");
    for (int k = 0; k < 5; k++) begin drive_lanes(4'hF); tick(); end
    check("mid_lane_ok", lane_ok, 4'hF);
    #2 rst_n = 1'b0;
    #1;
    check("async_state", state, 0);
    check("async_gtp_reset", gtp_reset, 1);
    check("async_dcm_reset", dcm_reset, 1);
    check("async_lane_ok", lane_ok, 0);
    check("async_link_up", link_up, 0);
    check("async_retry", retry_cnt, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 300 PLL timeouts: counter must stop at 255.
    pll_lock = 1'b0; restart = 1'b1; tick(); restart = 1'b0;
    for (int l = 0; l < 300; l++) begin
      for (int t = 0; t < RST_CYCLES + LOCK_TMO; t++) tick();
      if (l == 254 || l == 299) check("sat_retry", retry_cnt, 255);
    end
    check("sat_state", state, 0);

    if (passes + fails != checks) $error("FAIL bookkeeping observed=%0d expected=%0d", passes + fails, checks);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/gtp_link_ctrl.md
Name: gtp_link_ctrl

Overview:
- Bring-up and supervision controller for the 4-lane GTP receiver (2 tiles x 2 lanes, 16-bit words per lane, 125 MHz user clock from DCM).
- Sequences GTP reset, PLL lock, DCM reset/lock and RESETDONE, then qualifies per-lane comma alignment on idle K28.5 (BC) traffic and declares link_up.
- Afterwards it monitors the lanes and restarts the whole sequence on any failure, counting retries.
- clk must be a free-running clock independent of the GTP/DCM chain; all lane inputs are synchronised to clk by the integrator.

Parameters:
- RST_CYCLES, 64: cycles gtp_reset is held high in S_RESET.
- LOCK_TMO, 65536: per-state timeout in S_WAITPLL, S_WAITDCM and S_WAITRDY, in cycles.
- ALIGN_CNT, 16: consecutive comma words a lane needs to be marked ok.
- ALIGN_TMO, 4096: timeout in S_ALIGN, in cycles.
- IDLE_TMO, 1024: maximum cycles without a comma word on a lane while in S_UP.

Ports:
- clk  in  1  free-running controller clock
- rst_n  in  1  asynchronous active-low reset
- restart  in  1  single-cycle request to re-run bring-up; does not count as a retry
- pll_lock  in  1  GTP tile0 PLLLKDET
- dcm_locked  in  1  DCM LOCKED
- resetdone  in  4  GTP RESETDONE per lane
- lossofsync  in  4  per-lane RXLOSSOFSYNC[1] (loss-of-sync flag)
- data  in  64  lane i word = data[16i+15:16i]
- charisk  in  4  per-lane K flag (lane i = charisk[i])
- gtp_reset  out  1  GTPRESET to both tiles
- dcm_reset  out  1  DCM RST
- link_up  out  1  all lanes aligned and healthy
- lane_ok  out  4  per-lane aligned flag
- retry_cnt  out  8  failure-triggered restarts, saturating
- state  out  3  current FSM state code, for debug

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=S_RESET(0), gtp_reset=1, dcm_reset=1, link_up=0, lane_ok=0, retry_cnt=0.
  - Timer and per-lane counters are cleared.
- Registering: all outputs are registered and track state with no extra delay.
- Comma word (lane i): charisk[i]=1 AND data[16i+7:16i]==8'hBC.
- Single timer (17 bits) is cleared on every state entry.
- S_RESET(0):
  - gtp_reset=1, dcm_reset=1, lane_ok=0.
  - After RST_CYCLES cycles -> S_WAITPLL.
- S_WAITPLL(1):
  - gtp_reset=0, dcm_reset=1.
  - pll_lock=1 -> S_WAITDCM.
  - Timer reaching LOCK_TMO -> fail.
- S_WAITDCM(2):
  - dcm_reset=0.
  - dcm_locked=1 -> S_WAITRDY.
  - Timer reaching LOCK_TMO -> fail.
- S_WAITRDY(3):
  - resetdone==4'hF -> S_ALIGN.
  - Timer reaching LOCK_TMO -> fail.
- S_ALIGN(4):
  - Per-lane 5-bit counter increments on each comma word and clears on a non-comma word, but only while lane_ok[i]=0.
  - lane_ok[i] is set the cycle after the counter reaches ALIGN_CNT and stays set for the rest of S_ALIGN.
  - lane_ok==4'hF -> S_UP on the next cycle.
  - Timer reaching ALIGN_TMO -> fail.
- S_UP(5):
  - link_up=1.
  - Per-lane idle timer clears on a comma word and otherwise increments.
  - Fail if any of these occurs:
    - any idle timer reaches IDLE_TMO;
    - any lossofsync bit = 1;
    - pll_lock=0;
    - dcm_locked=0.
  - On fail, link_up and lane_ok clear in the same cycle as the state change.
- Lock-loss priority: in S_WAITDCM, S_WAITRDY and S_ALIGN, pll_lock=0 -> fail immediately; in S_ALIGN, dcm_locked=0 -> fail immediately.
- Fail: -> S_RESET and retry_cnt+1, saturating at 255.
- restart=1 in any state: -> S_RESET with no retry increment. If restart and a fail condition occur in the same cycle, restart wins (no increment).
- Codes 6 and 7 are unused; if ever reached -> S_RESET.

Test Plan:
- Overrides for all tests: RST_CYCLES=4, LOCK_TMO=100, ALIGN_CNT=4, ALIGN_TMO=50, IDLE_TMO=8.
- Clean bring-up:
  - Stimulus: pll_lock at cycle 10, dcm_locked at 20, resetdone=F at 25, all lanes sending BCBC with charisk=F.
  - Expected: gtp_reset low after 4 cycles; lane_ok=F 5 cycles after entering S_ALIGN; link_up=1 one cycle later; retry_cnt=0.
- PLL lock timeout:
  - Stimulus: pll_lock held at 0.
  - Expected: state returns to 0 after 100 cycles in S_WAITPLL; retry_cnt increments 1, 2, 3 on each loop.
- Lane 2 never aligns:
  - Stimulus: lane 2 sends data 0x1234 with charisk[2]=0.
  - Expected: lane_ok=4'b1011, then fail at timer 50; retry_cnt=1.
- Idle loss in S_UP:
  - Stimulus: lane 1 stops sending commas.
  - Expected: link_up drops when its idle timer hits 8; state=0; retry_cnt increments.
- lossofsync[3] pulse in S_UP:
  - Expected: immediate fail.
  - Same-cycle variant: restart together with lossofsync -> state 0 with retry_cnt unchanged.
- Reset mid-align:
  - Stimulus: rst_n low during S_ALIGN.
  - Expected: outputs return to reset values asynchronously; retry_cnt=0.
- Saturation:
  - Stimulus: force 300 timeouts.
  - Expected: retry_cnt stays at 255.
